// File: rtl/forward_hazard_unit.sv
// EX-stage forwarding selects and load-use stall generation for the five-stage pipeline.
// Keeps a shadow copy of destination info for ID/EX, EX/MEM and MEM/WB, fed from ID.
module forward_hazard_unit #(
  parameter int REG_BITS = 5,
  parameter int CNT_BITS = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [REG_BITS-1:0] ID_Rs,
  input  logic [REG_BITS-1:0] ID_Rt,
  input  logic [REG_BITS-1:0] ID_Dest,
  input  logic                ID_RegWrite,
  input  logic                ID_MemRead,
  input  logic                Flush,
  output logic [1:0]          ForwardA_signal,
  output logic [1:0]          ForwardB_signal,
  output logic                Stall,
  output logic [CNT_BITS-1:0] StallCount
);

  logic [REG_BITS-1:0] idexRs;
  logic [REG_BITS-1:0] idexRt;
  logic [REG_BITS-1:0] idexDest;
  logic                idexRegWrite;
  logic                idexMemRead;
  logic [REG_BITS-1:0] exmemDest;
  logic                exmemRegWrite;
  logic [REG_BITS-1:0] memwbDest;
  logic                memwbRegWrite;
  logic                exmemHitA;
  logic                exmemHitB;
  logic                memwbHitA;
  logic                memwbHitB;
  logic                bubble;

  // A flushed or stalled ID instruction enters ID/EX as an all-zero bubble.
  assign bubble = Stall | Flush;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      idexRs        <= '0;
      idexRt        <= '0;
      idexDest      <= '0;
      idexRegWrite  <= 1'b0;
      idexMemRead   <= 1'b0;
      exmemDest     <= '0;
      exmemRegWrite <= 1'b0;
      memwbDest     <= '0;
      memwbRegWrite <= 1'b0;
    end else begin
      memwbDest     <= exmemDest;
      memwbRegWrite <= exmemRegWrite;
      exmemDest     <= idexDest;
      exmemRegWrite <= idexRegWrite;
      if (bubble) begin
        idexRs       <= '0;
        idexRt       <= '0;
        idexDest     <= '0;
        idexRegWrite <= 1'b0;
        idexMemRead  <= 1'b0;
      end else begin
        idexRs       <= ID_Rs;
        idexRt       <= ID_Rt;
        idexDest     <= ID_Dest;
        idexRegWrite <= ID_RegWrite;
        idexMemRead  <= ID_MemRead;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      StallCount <= '0;
    end else if (Stall && (StallCount != {CNT_BITS{1'b1}})) begin
      StallCount <= StallCount + 1'b1;
    end
  end

  // Register 0 is hardwired, so a write to it never produces a forward or a stall.
  always_comb begin
    exmemHitA = exmemRegWrite && (exmemDest != '0) && (exmemDest == idexRs);
    exmemHitB = exmemRegWrite && (exmemDest != '0) && (exmemDest == idexRt);
    memwbHitA = memwbRegWrite && (memwbDest != '0) && (memwbDest == idexRs);
    memwbHitB = memwbRegWrite && (memwbDest != '0) && (memwbDest == idexRt);
  end

  // The younger EX/MEM value takes priority over MEM/WB.
  always_comb begin
    ForwardA_signal = 2'b00;
    ForwardB_signal = 2'b00;
    if (exmemHitA)      ForwardA_signal = 2'b10;
    else if (memwbHitA) ForwardA_signal = 2'b01;
    if (exmemHitB)      ForwardB_signal = 2'b10;
    else if (memwbHitB) ForwardB_signal = 2'b01;
  end

  always_comb begin
    Stall = idexMemRead && idexRegWrite && (idexDest != '0) &&
            ((idexDest == ID_Rs) || (idexDest == ID_Rt)) && !Flush;
  end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Self-checking bench for forward_hazard_unit: directed hazard scenarios plus random traffic
// compared against an instruction-level pipeline model.
module tb_forward_hazard_unit;

  localparam int REG = 5;
  localparam int CNT = 8;
  localparam int CNT_MAX = (1 << CNT) - 1;

  typedef struct packed {
    logic [REG-1:0] rs;
    logic [REG-1:0] rt;
    logic [REG-1:0] dest;
    logic           rw;
    logic           mr;
  } instr_t;

  logic           Clk;
  logic           Reset;
  logic [REG-1:0] ID_Rs;
  logic [REG-1:0] ID_Rt;
  logic [REG-1:0] ID_Dest;
  logic           ID_RegWrite;
  logic           ID_MemRead;
  logic           Flush;
  logic [1:0]     ForwardA_signal;
  logic [1:0]     ForwardB_signal;
  logic           Stall;
  logic [CNT-1:0] StallCount;

  int checks = 0;
  int errors = 0;

  // pipe[0]=ID/EX, pipe[1]=EX/MEM, pipe[2]=MEM/WB as whole instructions
  instr_t pipe[3];
  int     refCount;

  forward_hazard_unit #(.REG_BITS(REG), .CNT_BITS(CNT)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .ID_Rs(ID_Rs),
    .ID_Rt(ID_Rt),
    .ID_Dest(ID_Dest),
    .ID_RegWrite(ID_RegWrite),
    .ID_MemRead(ID_MemRead),
    .Flush(Flush),
    .ForwardA_signal(ForwardA_signal),
    .ForwardB_signal(ForwardB_signal),
    .Stall(Stall),
    .StallCount(StallCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Youngest older instruction that writes the source register supplies the value.
  function automatic logic [1:0] refForward(input logic [REG-1:0] src);
    for (int s = 1; s <= 2; s++) begin
      if (pipe[s].rw && pipe[s].dest != 0 && pipe[s].dest == src)
        return (s == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  function automatic logic refStall();
    return pipe[0].mr && pipe[0].rw && pipe[0].dest != 0 &&
           (pipe[0].dest == ID_Rs || pipe[0].dest == ID_Rt) && !Flush;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Consumes the inputs held over the next rising edge, then drives new ones and checks.
  task automatic applyStimulus(input logic [REG-1:0] rs, input logic [REG-1:0] rt,
                               input logic [REG-1:0] dest, input logic rw, input logic mr,
                               input logic fl, input logic rst);
    logic s;
    instr_t cur;
    @(posedge Clk);
    if (Reset) begin
      for (int i = 0; i < 3; i++) pipe[i] = '0;
      refCount = 0;
    end else begin
      s = refStall();
      cur = '{rs: ID_Rs, rt: ID_Rt, dest: ID_Dest, rw: ID_RegWrite, mr: ID_MemRead};
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (s || Flush) ? instr_t'('0) : cur;
      if (s && refCount < CNT_MAX) refCount++;
    end
    @(negedge Clk);
    ID_Rs = rs; ID_Rt = rt; ID_Dest = dest;
    ID_RegWrite = rw; ID_MemRead = mr; Flush = fl; Reset = rst;
    #1;
    checkOutput("fwdA", 16'(ForwardA_signal), 16'(refForward(pipe[0].rs)));
    checkOutput("fwdB", 16'(ForwardB_signal), 16'(refForward(pipe[0].rt)));
    checkOutput("stall", 16'(Stall), 16'(refStall()));
    checkOutput("count", 16'(StallCount), 16'(refCount));
  endtask

  task automatic nop();
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    Reset = 1'b1; Flush = 1'b0;
    ID_Rs = '0; ID_Rt = '0; ID_Dest = '0; ID_RegWrite = 1'b0; ID_MemRead = 1'b0;
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    refCount = 0;

    $display("[TB] reset with random ID inputs");
    repeat (2) applyStimulus(5'($urandom), 5'($urandom), 5'($urandom),
                             1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    nop();
    checkOutput("rst_fwdA", 16'(ForwardA_signal), 16'h0);
    checkOutput("rst_fwdB", 16'(ForwardB_signal), 16'h0);
    checkOutput("rst_stall", 16'(Stall), 16'h0);
    checkOutput("rst_count", 16'(StallCount), 16'h0);

    $display("[TB] ALU forwarding from EX/MEM and MEM/WB");
    applyStimulus(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(5'd3, 5'd6, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(5'd8, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("raw_exmem_A", 16'(ForwardA_signal), 16'h2);
    nop();
    checkOutput("raw_memwb_B", 16'(ForwardB_signal), 16'h1);

    $display("[TB] double write priority");
    applyStimulus(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(5'd5, 5'd10, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
    nop();
    checkOutput("prio_A", 16'(ForwardA_signal), 16'h2);

    $display("[TB] load-use stall");
    applyStimulus(5'd1, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(5'd2, 5'd4, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_stall", 16'(Stall), 16'h1);
    applyStimulus(5'd2, 5'd4, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_stall_once", 16'(Stall), 16'h0);
    checkOutput("lu_count", 16'(StallCount), 16'h1);
    nop();
    checkOutput("lu_fwdB", 16'(ForwardB_signal), 16'h1);

    $display("[TB] load-use with flush");
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(5'd1, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(5'd2, 5'd4, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("fl_stall", 16'(Stall), 16'h0);
    nop();
    checkOutput("fl_fwdA", 16'(ForwardA_signal), 16'h0);
    checkOutput("fl_fwdB", 16'(ForwardB_signal), 16'h0);
    checkOutput("fl_count", 16'(StallCount), 16'h0);

    $display("[TB] register zero");
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(5'd0, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("r0_stall", 16'(Stall), 16'h0);
    nop();
    checkOutput("r0_fwdA", 16'(ForwardA_signal), 16'h0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0),
                    1'($urandom_range(0, 63) == 0));
    end

    $display("[TB] stall counter saturation");
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2 * (CNT_MAX + 4); i++) begin
      applyStimulus(5'd4, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    nop();
    checkOutput("sat_count", 16'(StallCount), 16'(CNT_MAX));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/forward_hazard_unit.md
Name: forward_hazard_unit

Overview:
- Control-side counterpart of the EX-stage operand muxes. It generates ForwardA/ForwardB select codes and the load-use stall for the five-stage pipeline.
- It keeps its own shadow copy of destination info for the ID/EX, EX/MEM and MEM/WB stages, fed once per cycle from the ID stage.
- Select outputs drive the EX operand muxes. Stall drives PC/IF-ID write-enable and bubble injection.

Parameters:
- REG_BITS, 5, register specifier width
- CNT_BITS, 16, width of stall performance counter

Ports:
- Clk  input  1  pipeline clock, all state updates on rising edge
- Reset  input  1  synchronous, active-high; clears all state on the rising edge where it is high
- ID_Rs  input  REG_BITS  source register 1 of instruction in ID
- ID_Rt  input  REG_BITS  source register 2 of instruction in ID
- ID_Dest  input  REG_BITS  destination register of instruction in ID (already muxed rt/rd/31)
- ID_RegWrite  input  1  ID instruction writes the register file
- ID_MemRead  input  1  ID instruction is a load
- Flush  input  1  branch/jump taken; squash the instruction in ID
- ForwardA_signal  output  2  EX operand A select
- ForwardB_signal  output  2  EX operand B select
- Stall  output  1  hold PC and IF/ID; insert bubble into ID/EX
- StallCount  output  CNT_BITS  number of stall cycles since reset, saturating

Behaviour:
- Shadow state: IDEX{rs, rt, dest, regwrite, memread}, EXMEM{dest, regwrite}, MEMWB{dest, regwrite}.
- Every edge (Reset low):
  - MEMWB <= EXMEM
  - EXMEM <= IDEX{dest, regwrite}
  - IDEX <= ID inputs, or a bubble (all fields 0) when Stall=1 or Flush=1.
- Reset: all shadow fields 0, StallCount=0. ForwardA_signal=ForwardB_signal=2'b00 and Stall=0 in the cycle after the reset edge. Reset mid-stall drops Stall the following cycle.
- Forward codes (combinational from shadow state only, 0-cycle latency to EX):
  - 2'b00: register file value
  - 2'b10: EX/MEM ALU result
  - 2'b01: MEM/WB write data
  - 2'b11 is never produced.
- ForwardA:
  - 2'b10 if EXMEM.regwrite and EXMEM.dest!=0 and EXMEM.dest==IDEX.rs
  - else 2'b01 if MEMWB.regwrite and MEMWB.dest!=0 and MEMWB.dest==IDEX.rs
  - else 2'b00.
- ForwardB: same rules against IDEX.rt.
- Priority: EX/MEM beats MEM/WB when both match (youngest value wins).
- Register 0 is never forwarded and never causes a stall.
- Stall (combinational, from IDEX and current ID inputs):
  - Asserted when IDEX.memread and IDEX.regwrite and IDEX.dest!=0 and (IDEX.dest==ID_Rs or IDEX.dest==ID_Rt) and Flush=0.
  - A load-use hazard produces exactly one stall cycle. After the bubble, the load sits in EX/MEM and its data is forwarded from MEM/WB (2'b01) when the dependent instruction reaches EX.
- Flush with a concurrent hazard: Flush wins. Stall=0, bubble written to IDEX, StallCount not incremented.
- StallCount increments by 1 on each edge where Stall=1 and Reset=0, and saturates at all-ones.
- No other outputs are registered; the forward selects are glitch-free as long as the shadow registers are.

Test Plan:
- Reset held 2 cycles with random ID inputs -> ForwardA/B=00, Stall=0, StallCount=0 after release.
- add $3 (Dest=3, RegWrite=1), then sub using Rs=3 -> ForwardA=10 when sub is in IDEX; next ID using Rt=3 -> ForwardB=01.
- Two consecutive writes to $5, then an instruction reading Rs=5 -> ForwardA=10, not 01.
- lw $4 (MemRead=1, Dest=4), then ID with Rt=4 -> Stall=1 for exactly one cycle, StallCount=1. The dependent instruction then enters IDEX with ForwardB=01.
- Same load-use sequence with Flush=1 in the hazard cycle -> Stall=0, StallCount stays 0, IDEX bubble (no forwarding the next cycle).
- Write to $0 with RegWrite=1, then read Rs=0 -> ForwardA=00 and no stall. Also force 2^CNT_BITS+3 stalls -> StallCount holds at all-ones.
